// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if: load/key/schedule bundle between key expander and cipher (clear port with AES_KEY_CLEAR_EN)
interface aes_key_expand_if #(parameter int Nk = 4, parameter int Nr = Nk + 6);
`ifdef AES_KEY_CLEAR_EN
  logic clear;
`endif
  logic load;
  logic [32*Nk-1:0] key;
  logic busy;
  logic ready;
  logic [127:0] k_sch [0:Nr];
  modport master (
`ifdef AES_KEY_CLEAR_EN
    output clear,
`endif
    output load, key,
    input busy, ready, k_sch
  );
  modport slave (
`ifdef AES_KEY_CLEAR_EN
    input clear,
`endif
    input load, key,
    output busy, ready, k_sch
  );
endinterface

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES key schedule, one word per cycle; AES_KEY_CLEAR_EN adds a synchronous clear
module aes_key_expand #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input logic clk,
  input logic rst,
  aes_key_expand_if.slave kx
);
  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] NK_W = 6'(Nk);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [2:0] WRAP_MAX = 3'(Nk - 1);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] i_q, i_d;
  logic [2:0] wrap_q, wrap_d;
  logic [7:0] rcon_q, rcon_d;
  logic [31:0] w_q [NW];
  logic [31:0] prev, sub, t, w_new;
  logic clr, start;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

`ifdef AES_KEY_CLEAR_EN
  assign clr = kx.clear;
`else
  assign clr = 1'b0;
`endif
  assign start = kx.load && state_q != EXPAND && !clr;
  assign kx.busy = state_q == EXPAND;
  assign kx.ready = state_q == DONE;

  for (genvar r = 0; r <= Nr; r++) begin : g_ks
    assign kx.k_sch[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
  end

  // next schedule word: wrap_q tracks i mod Nk so no divider is needed
  always_comb begin
    prev = w_q[i_q - 6'd1];
    sub = sub_word(wrap_q == 3'd0 ? {prev[23:0], prev[31:24]} : prev);
    t = wrap_q == 3'd0 ? sub ^ {rcon_q, 24'h0} : (Nk == 8 && wrap_q == 3'd4) ? sub : prev;
    w_new = w_q[i_q - NK_W] ^ t;
  end

  // FSM and counter next-state; clear beats load, load is ignored while expanding
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    wrap_d = wrap_q;
    rcon_d = rcon_q;
    if (clr) begin
      state_d = IDLE;
      i_d = 6'd0;
      wrap_d = 3'd0;
      rcon_d = 8'h01;
    end else if (start) begin
      state_d = EXPAND;
      i_d = NK_W;
      wrap_d = 3'd0;
      rcon_d = 8'h01;
    end else if (state_q == EXPAND) begin
      state_d = i_q == LAST ? DONE : EXPAND;
      i_d = i_q + 6'd1;
      wrap_d = wrap_q == WRAP_MAX ? 3'd0 : wrap_q + 3'd1;
      rcon_d = wrap_q == 3'd0 ? {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00) : rcon_q;
    end
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= 6'd0;
      wrap_q <= 3'd0;
      rcon_q <= 8'h01;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      wrap_q <= wrap_d;
      rcon_q <= rcon_d;
    end
  end

  // schedule words: key words land together on load, then one derived word per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
    end else if (start) begin
      for (int j = 0; j < Nk; j++) w_q[j] <= kx.key[32*(Nk-j)-1 -: 32];
    end else if (state_q == EXPAND) begin
      w_q[i_q] <= w_new;
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: checks Nk=4/6/8 expanders against FIPS-197 vectors and a GF(2^8)-derived reference schedule
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] ld = 3'b000;
  logic [255:0] key_a [3];
`ifdef AES_KEY_CLEAR_EN
  logic clr = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_m [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_expand_if #(.Nk(4)) if4();
  aes_key_expand_if #(.Nk(6)) if6();
  aes_key_expand_if #(.Nk(8)) if8();
  assign if4.load = ld[0];
  assign if6.load = ld[1];
  assign if8.load = ld[2];
  assign if4.key = key_a[0][127:0];
  assign if6.key = key_a[1][191:0];
  assign if8.key = key_a[2];
`ifdef AES_KEY_CLEAR_EN
  assign if4.clear = clr;
  assign if6.clear = clr;
  assign if8.clear = clr;
`endif
  aes_key_expand #(.Nk(4)) u4 (.clk(clk), .rst(rst), .kx(if4));
  aes_key_expand #(.Nk(6)) u6 (.clk(clk), .rst(rst), .kx(if6));
  aes_key_expand #(.Nk(8)) u8 (.clk(clk), .rst(rst), .kx(if8));

  function automatic int nk_of(input int n); return 4 + 2 * n; endfunction
  function automatic int nr_of(input int n); return nk_of(n) + 6; endfunction
  function automatic logic busy_f(input int n);
    return n == 0 ? if4.busy : n == 1 ? if6.busy : if8.busy;
  endfunction
  function automatic logic ready_f(input int n);
    return n == 0 ? if4.ready : n == 1 ? if6.ready : if8.ready;
  endfunction
  function automatic logic [127:0] rk(input int n, input int r);
    return n == 0 ? if4.k_sch[r] : n == 1 ? if6.k_sch[r] : if8.k_sch[r];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] b;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic expand_m(input int nk, input logic [255:0] k);
    logic [7:0] rc = 8'h01;
    for (int j = 0; j < nk; j++) mw[j] = k[32*(nk-j)-1 -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      logic [31:0] t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int n, input string nm);
    logic [127:0] acc = '0;
    for (int r = 0; r <= nr_of(n); r++) acc = acc | rk(n, r);
    chk(nm, {busy_f(n), ready_f(n)}, 0);
    chk(nm, acc, 0);
  endtask

  task automatic chk_sched(input int n, input logic [255:0] k, input string nm);
    expand_m(nk_of(n), k);
    for (int r = 0; r <= nr_of(n); r++) chk(nm, rk(n, r), {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
  endtask

  task automatic wait_rdy(input int n, output int lat, output int bc);
    lat = 1;
    bc = 0;
    while (!ready_f(n) && lat < 200) begin
      bc += int'(busy_f(n));
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input int n, input logic [255:0] k, output int lat, output int bc);
    key_a[n] = k;
    ld[n] = 1'b1;
    @(posedge clk); #1;
    ld[n] = 1'b0;
    chk("start_busy", busy_f(n), 1);
    chk("start_ready", ready_f(n), 0);
    wait_rdy(n, lat, bc);
  endtask

  typedef struct {
    int n;
    logic [255:0] key;
    int r;
    logic [127:0] exp;
    int lat;
  } vec_t;

  localparam logic [255:0] KEY_A1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    vec_t tv[4];
    int lat, bc;
    logic [255:0] k;
    tv[0] = '{0, KEY_A1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 41};
    tv[1] = '{0, KEY_A1, 10, RK10_A1, 41};
    tv[2] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 12, 128'he98ba06f448c773c8ecc720401002202, 47};
    tv[3] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 14, 128'hfe4890d1e6188d0b046df344706c631e, 53};
    for (int n = 0; n < 3; n++) key_a[n] = '0;
    build_sbox();
    #1;
    for (int n = 0; n < 3; n++) chk_zero(n, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run(tv[v].n, tv[v].key, lat, bc);
      chk("latency", lat, tv[v].lat);
      chk("busy_cycles", bc, tv[v].lat - 1);
      chk("fips_round_key", rk(tv[v].n, tv[v].r), tv[v].exp);
      chk_sched(tv[v].n, tv[v].key, "fips_schedule");
    end

    for (int it = 0; it < 3; it++)
      for (int n = 0; n < 3; n++) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(n, k, lat, bc);
        chk("rand_latency", lat, 4 * (nk_of(n) + 7) - nk_of(n) + 1);
        chk_sched(n, k, "rand_schedule");
        repeat (3) @(posedge clk);
        #1 chk_sched(n, k, "done_hold");
      end

    key_a[0] = KEY_A1;
    ld[0] = 1'b1;
    @(posedge clk); #1;
    ld[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 key_a[0] = 256'h000102030405060708090a0b0c0d0e0f;
    ld[0] = 1'b1;
    @(posedge clk); #1;
    ld[0] = 1'b0;
    chk("ignored_load_busy", busy_f(0), 1);
    wait_rdy(0, lat, bc);
    chk("ignored_load_latency", lat, 31);
    chk("ignored_load_rk10", rk(0, 10), RK10_A1);
    chk_sched(0, KEY_A1, "ignored_load_sched");

    key_a[0] = 256'h000102030405060708090a0b0c0d0e0f;
    ld[0] = 1'b1;
    @(posedge clk); #1;
    ld[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero(0, "async_reset");
    @(negedge clk);
    rst = 1'b0;
    run(0, KEY_A1, lat, bc);
    chk("post_reset_latency", lat, 41);
    chk("post_reset_rk10", rk(0, 10), RK10_A1);
    chk_sched(0, KEY_A1, "post_reset_sched");

`ifdef AES_KEY_CLEAR_EN
    clr = 1'b1;
    key_a[0] = 256'h000102030405060708090a0b0c0d0e0f;
    ld[0] = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    ld[0] = 1'b0;
    chk_zero(0, "clear_now");
    repeat (3) @(posedge clk);
    #1 chk_zero(0, "clear_stays_idle");
    run(0, KEY_A1, lat, bc);
    chk("post_clear_latency", lat, 41);
    chk("post_clear_rk10", rk(0, 10), RK10_A1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
